instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch-side initiator for the 16-bit compressed-instruction instruction memory. It holds the program counter and drives the halfword read address to the memory. It captures the returned 16-bit instruction into a small prefetch queue and presents instruction/PC pairs to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new target.

## Interface
- RESET_PC, 16'h0000: PC value loaded on reset.
- FIFO_DEPTH, 2: prefetch queue entries; power of two, ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  16  byte address to instruction memory; bit 0 always 0.
- imem_rdata  in  16  instruction returned combinationally for imem_addr in the same cycle.
- if_valid  out  1  if_instr/if_pc hold a valid fetched instruction.
- if_instr  out  16  instruction at head of queue.
- if_pc  out  16  address of if_instr.
- id_ready  in  1  decode accepts head entry when if_valid && id_ready.
- redirect_valid  in  1  flush and refetch request from execute.
- redirect_pc  in  16  new fetch target.
- fetch_fault  out  1  misaligned redirect trap; only with the macro, else tied 0.

## Operation
- State: pc register (fetch PC), queue of {instr, pc} entries, count.
- imem_addr = pc. It is register-driven with no combinational path from inputs.
- Enqueue condition each cycle: !redirect_valid && !halted && (count < FIFO_DEPTH || deq). deq = if_valid && id_ready.
  - On enqueue: push {imem_rdata, pc} and set pc <= pc + 2.
  - Otherwise pc holds.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000.
- Out-of-range memory reads return 16'h0000. That value is enqueued as an ordinary instruction; there is no decode of content.
- Redirect has priority over every other event in the same cycle:
  - count <= 0.
  - pc <= redirect_pc with bit 0 forced 0; see Configuration for the macro case.
  - That cycle's imem_rdata is discarded.
  - A simultaneous deq is still considered consumed by decode. Its entry is flushed regardless.
- Queue full with no deq: no enqueue, pc holds, imem_addr stable.
- Full with deq in the same cycle: enqueue and dequeue both occur, count unchanged.
- Empty: if_valid=0. if_instr/if_pc are don't-care but must not be X after reset.

## Timing
- Reset values while rst_n=0: pc=RESET_PC, imem_addr=RESET_PC, count=0, if_valid=0, if_instr=0, if_pc=0, fetch_fault=0, halted=0.
- Reset asserted mid-operation clears the queue and PC asynchronously. Fetch resumes on the first rising edge after deassertion.
- Fetch latency: the instruction at address A is enqueued on the edge ending the cycle where imem_addr=A. if_valid is high the next cycle.
- After reset release, the first edge enqueues RESET_PC. if_valid=1 in the following cycle.
- Redirect at cycle N: imem_addr=target in N+1, enqueue at end of N+1, if_valid=1 in N+2. Redirect-to-valid is 2 cycles.
- Steady state with id_ready held high: one instruction per cycle, PCs consecutive by 2.
- id_ready low for k cycles: queue fills after FIFO_DEPTH enqueues, then fetch stalls. Rising id_ready resumes 1 instr/cycle with no bubble.

## Configuration
- IFU_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[0]=1 sets fetch_fault=1 and halted=1, and flushes the queue.
  - pc is loaded with redirect_pc & 16'hFFFE.
  - No enqueues occur while halted.
  - The next redirect with an even target clears fetch_fault and halted.
- Undefined: bit 0 is silently cleared, fetch_fault is constant 0, and the halted logic is absent.

## Structure
- Shared package cpu16_pkg: XLEN=16, ILEN=16, typedef pc_t (16-bit), typedef fetch_entry_t {instr, pc}, default RESET_PC.
- Sub-module ifu_prefetch_fifo: FIFO_DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Circular read/write pointers.
- The top level holds the PC, enqueue logic, redirect/fault handling, and port mapping.

## Test plan
- Reset, memory returns 16'h0001 at 0, 16'h0D91 at 2, id_ready=1 -> imem_addr 0,2,4,…; first if_valid cycle gives if_pc=0, if_instr=16'h0001, next gives if_pc=2, 16'h0D91.
- id_ready=0 for 5 cycles -> exactly 2 entries (pc 0,2) held, imem_addr frozen at 4; id_ready=1 -> pc 0,2,4 delivered back-to-back.
- Redirect to 16'h0030 while queue full and id_ready=1 -> queue flushed, imem_addr=16'h0030 next cycle, if_valid with if_pc=16'h0030 two cycles after redirect.
- Redirect to 16'hFFFE -> delivered pcs 16'hFFFE then 16'h0000.
- Redirect to 16'h0031 with IFU_MISALIGN_TRAP_EN -> fetch_fault=1, no if_valid until redirect to 16'h0010 clears it; without the macro -> fetch resumes at 16'h0030.
- rst_n pulsed low mid-stream -> if_valid=0 and imem_addr=RESET_PC immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared types for the 16-bit compressed-instruction fetch path.
package cpu16_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned ILEN = 16;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [ILEN-1:0] instr_t;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  localparam pc_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch_entry_t with
// circular read/write pointers. DEPTH must be a power of two, >= 2.
module ifu_prefetch_fifo
  import cpu16_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;

  // Pointer, occupancy and storage update; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: owns the fetch PC, drives the halfword address to
// instruction memory, queues returned instructions for decode and handles
// redirects from execute.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (odd redirect target traps
// and halts fetch until the next even redirect).
module instruction_fetch_unit
  import cpu16_pkg::*;
#(
  parameter pc_t         RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  pc_t          pc_q;
  pc_t          pc_d;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_entry_t wdata;
  logic         deq;
  logic         enq;
  logic         halted;

`ifdef IFU_MISALIGN_TRAP_EN
  logic halted_q;

  // Odd redirect target traps; any later redirect re-evaluates the trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= redirect_pc[0];
    end
  end

  assign halted      = halted_q;
  assign fetch_fault = halted_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];
  assign halted              = 1'b0;
  assign fetch_fault         = 1'b0;
`endif

  assign deq = if_valid && id_ready;
  assign enq = !redirect_valid && !halted && ((count < FULL_COUNT) || deq);

  // Next fetch PC: redirect wins, otherwise advance only when an entry was queued.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[15:1], 1'b0};
    end else if (enq) begin
      pc_d = pc_q + 16'd2;
    end
  end

  // Fetch PC register; it alone drives imem_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign wdata = '{instr: imem_rdata, pc: pc_q};

  ifu_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq && !redirect_valid),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign imem_addr = pc_q;
  assign if_valid  = (count != '0);
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  // Memory image: two fixed words, a formula below 0x200, zero elsewhere.
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0001;
    if (a == 16'h0002) return 16'h0D91;
    if (a < 16'h0200)  return a * 16'd3 + 16'h1234;
    return 16'h0000;
  endfunction

  assign imem_rdata = mem_rd(imem_addr);

  instruction_fetch_unit #(
    .RESET_PC   (16'h0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {instr, pc}, fetch pc, trap flag.
  logic [31:0] mq[$];
  logic [15:0] mpc;
  logic        mfault;

  task automatic model_reset();
    mq.delete();
    mpc    = 16'h0000;
    mfault = 1'b0;
  endtask

  task automatic model_step();
    logic deq;
    int   sz;
    sz  = mq.size();
    deq = (sz != 0) && id_ready;
    if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & 16'hFFFE;
      if (TRAP) mfault = redirect_pc[0];
    end else begin
      if (deq) void'(mq.pop_front());
      if (!mfault && (sz < DEPTH || deq)) begin
        mq.push_back({mem_rd(mpc), mpc});
        mpc = mpc + 16'd2;
      end
    end
  endtask

  task automatic check_model();
    chk("m_valid", {15'd0, if_valid}, {15'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("m_pc", if_pc, mq[0][15:0]);
      chk("m_instr", if_instr, mq[0][31:16]);
    end
    chk("m_addr", imem_addr, mpc);
    chk("m_fault", {15'd0, fetch_fault}, {15'd0, mfault});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset pulse starting just after an edge; checks the asynchronous values.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {15'd0, if_valid}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_fault", {15'd0, fetch_fault}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] einstr;
    logic [15:0] eaddr;
    logic        ef;
  } vec_t;

  vec_t tv[19];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [15:0] rpc,
                              input logic ev, input logic [15:0] epc, input logic [15:0] einstr,
                              input logic [15:0] eaddr, input logic ef);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev;
    v.epc = epc; v.einstr = einstr; v.eaddr = eaddr; v.ef = ef;
    return v;
  endfunction

  initial begin
    // Directed sequence from reset: stall fill, drain, redirects, wrap, odd target.
    tv[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    tv[1]  = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0002, 0);
    tv[2]  = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0004, 0);
    tv[3]  = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0004, 0);
    tv[4]  = mk(0, 0, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0004, 0);
    tv[5]  = mk(1, 0, 16'h0000, 1, 16'h0000, 16'h0001, 16'h0004, 0);
    tv[6]  = mk(1, 0, 16'h0000, 1, 16'h0002, 16'h0D91, 16'h0006, 0);
    tv[7]  = mk(1, 0, 16'h0000, 1, 16'h0004, 16'h1240, 16'h0008, 0);
    tv[8]  = mk(1, 1, 16'h0030, 1, 16'h0006, 16'h1246, 16'h000A, 0);
    tv[9]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0030, 0);
    tv[10] = mk(1, 0, 16'h0000, 1, 16'h0030, 16'h12C4, 16'h0032, 0);
    tv[11] = mk(1, 1, 16'hFFFE, 1, 16'h0032, 16'h12CA, 16'h0034, 0);
    tv[12] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'hFFFE, 0);
    tv[13] = mk(1, 0, 16'h0000, 1, 16'hFFFE, 16'h0000, 16'h0000, 0);
    tv[14] = mk(1, 1, 16'h0031, 1, 16'h0000, 16'h0001, 16'h0002, 0);
    tv[15] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0030, TRAP);
    tv[16] = mk(1, 1, 16'h0010, !TRAP, 16'h0030, 16'h12C4, TRAP ? 16'h0030 : 16'h0032, TRAP);
    tv[17] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010, 0);
    tv[18] = mk(1, 0, 16'h0000, 1, 16'h0010, 16'h1264, 16'h0012, 0);

    #1;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      id_ready       = tv[i].rdy;
      redirect_valid = tv[i].rv;
      redirect_pc    = tv[i].rpc;
      chk($sformatf("t%0d_valid", i), {15'd0, if_valid}, {15'd0, tv[i].ev});
      if (tv[i].ev) begin
        chk($sformatf("t%0d_pc", i), if_pc, tv[i].epc);
        chk($sformatf("t%0d_instr", i), if_instr, tv[i].einstr);
      end
      chk($sformatf("t%0d_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("t%0d_fault", i), {15'd0, fetch_fault}, {15'd0, tv[i].ef});
      @(posedge clk);
      #1;
    end

    // Randomised run against the model, with a mid-stream reset.
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        do_reset();
      end
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom_range(0, 1) ? 16'hFFFE : 16'hFFFF;
        default: redirect_pc = 16'($urandom_range(0, 16'h03FF));
      endcase
      check_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
